ofs_plat_prim_fifo_lane_packer: RTL

- Downstream consumer of the LUTRAM FIFO. Pops narrow entries through the FIFO's first/notEmpty/deq_en interface.
- Packs up to N_LANES consecutive entries into one wide beat and presents it on a registered valid/ready output.
- A per-entry last flag closes a beat early. The block is used to widen narrow request/response streams before wide datapaths.

---
 rtl/ofs_plat_prim_fifo_lane_packer_if.sv | 26 ++
 rtl/ofs_plat_prim_fifo_lane_packer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ofs_plat_prim_fifo_lane_packer_if.sv
// FIFO-pop and wide-beat handshake bundle for the lane packer.
// The master drives FIFO head/out_ready; the slave (packer) pops and presents beats.
interface ofs_plat_prim_fifo_lane_packer_if #(
    parameter int N_DATA_BITS = 32,
    parameter int N_LANES     = 4
);
    logic [N_DATA_BITS-1:0]         in_first;
    logic                           in_last;
    logic                           in_notEmpty;
    logic                           in_deq_en;
    logic [N_LANES*N_DATA_BITS-1:0] out_data;
    logic [N_LANES-1:0]             out_mask;
    logic                           out_last;
    logic                           out_valid;
    logic                           out_ready;

    modport master (
        output in_first, in_last, in_notEmpty, out_ready,
        input  in_deq_en, out_data, out_mask, out_last, out_valid
    );

    modport slave (
        input  in_first, in_last, in_notEmpty, out_ready,
        output in_deq_en, out_data, out_mask, out_last, out_valid
    );
endinterface

// File: rtl/ofs_plat_prim_fifo_lane_packer.sv
// Packs up to N_LANES narrow FIFO entries into one registered wide beat; in_last closes early.
// Optional idle timeout for partial beats: define OFS_PLAT_PRIM_FIFO_LANE_PACKER_TIMEOUT_EN.
module ofs_plat_prim_fifo_lane_packer #(
    parameter int N_DATA_BITS    = 32,
    parameter int N_LANES        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    ofs_plat_prim_fifo_lane_packer_if.slave io
);
    localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    typedef logic [N_LANES-1:0][N_DATA_BITS-1:0] lanes_t;

    lanes_t             stage_data_q, stage_data_d, merged_data;
    logic [N_LANES-1:0] stage_mask_q, stage_mask_d, merged_mask;
    logic [LW-1:0]      lane_idx_q, lane_idx_d;
    logic               stage_done_q, stage_done_d;
    logic               stage_last_q, stage_last_d;
    lanes_t             out_data_q, out_data_d;
    logic [N_LANES-1:0] out_mask_q, out_mask_d;
    logic               out_last_q, out_last_d;
    logic               out_valid_q, out_valid_d;

    logic out_free, pop, complete, close, close_last, timeout_fire;

`ifdef OFS_PLAT_PRIM_FIFO_LANE_PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_q, idle_d;
    logic          idle;

    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle with a partial stage.
    always_comb begin
        idle         = (stage_mask_q != '0) && !stage_done_q && !pop;
        timeout_fire = idle && (idle_q == TW'(TIMEOUT_CYCLES - 1));
        idle_d       = (idle && !timeout_fire) ? idle_q + TW'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) idle_q <= '0;
        else          idle_q <= idle_d;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_fire = 1'b0;
`endif

    always_comb begin
        out_free    = !out_valid_q || io.out_ready;
        pop         = io.in_notEmpty && !stage_done_q && reset_n;
        merged_data = stage_data_q;
        merged_mask = stage_mask_q;
        if (pop) begin
            merged_data[lane_idx_q] = io.in_first;
            merged_mask[lane_idx_q] = 1'b1;
        end
        complete   = pop && ((lane_idx_q == LW'(N_LANES - 1)) || io.in_last);
        close      = complete || timeout_fire;
        close_last = complete && io.in_last;

        stage_data_d = stage_data_q;
        stage_mask_d = stage_mask_q;
        lane_idx_d   = lane_idx_q;
        stage_done_d = stage_done_q;
        stage_last_d = stage_last_q;
        out_data_d   = out_data_q;
        out_mask_d   = out_mask_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;

        if (out_valid_q && io.out_ready) out_valid_d = 1'b0;

        if (stage_done_q) begin
            // Parked beat moves out; popping resumes the following cycle.
            if (out_free) begin
                out_data_d   = stage_data_q;
                out_mask_d   = stage_mask_q;
                out_last_d   = stage_last_q;
                out_valid_d  = 1'b1;
                stage_data_d = '0;
                stage_mask_d = '0;
                lane_idx_d   = '0;
                stage_done_d = 1'b0;
                stage_last_d = 1'b0;
            end
        end else if (close) begin
            if (out_free) begin
                out_data_d   = merged_data;
                out_mask_d   = merged_mask;
                out_last_d   = close_last;
                out_valid_d  = 1'b1;
                stage_data_d = '0;
                stage_mask_d = '0;
                lane_idx_d   = '0;
            end else begin
                stage_data_d = merged_data;
                stage_mask_d = merged_mask;
                stage_last_d = close_last;
                stage_done_d = 1'b1;
            end
        end else if (pop) begin
            stage_data_d = merged_data;
            stage_mask_d = merged_mask;
            lane_idx_d   = lane_idx_q + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage_data_q <= '0;
            stage_mask_q <= '0;
            lane_idx_q   <= '0;
            stage_done_q <= 1'b0;
            stage_last_q <= 1'b0;
            out_data_q   <= '0;
            out_mask_q   <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            stage_data_q <= stage_data_d;
            stage_mask_q <= stage_mask_d;
            lane_idx_q   <= lane_idx_d;
            stage_done_q <= stage_done_d;
            stage_last_q <= stage_last_d;
            out_data_q   <= out_data_d;
            out_mask_q   <= out_mask_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign io.in_deq_en = pop;
    assign io.out_data  = out_data_q;
    assign io.out_mask  = out_mask_q;
    assign io.out_last  = out_last_q;
    assign io.out_valid = out_valid_q;
endmodule
